// File: rtl/apu_frame_sequencer.sv
// APU $4017 frame counter: derives quarter/half-frame clocks and the frame IRQ
// from cpu_clk, and applies the delayed sequence reset after a $4017 write.

module apu_frame_sequencer #(
  parameter int Q1_CYCLE    = 7457,
  parameter int H1_CYCLE    = 14913,
  parameter int Q3_CYCLE    = 22371,
  parameter int STEP4_CYCLE = 29829,
  parameter int STEP5_CYCLE = 37281,
  parameter int CNT_W       = 16
) (
  input  logic       cpu_clk,
  input  logic       reset_n,
  input  logic       write_4017,
  input  logic [7:0] data_in,
  input  logic       status_read,
  output logic       quarter_clk,
  output logic       half_clk,
  output logic       quarter_pulse,
  output logic       half_pulse,
  output logic       frame_irq,
  output logic       mode,
  output logic       apu_phase
);

  localparam logic [CNT_W-1:0] Q1       = CNT_W'(Q1_CYCLE);
  localparam logic [CNT_W-1:0] H1       = CNT_W'(H1_CYCLE);
  localparam logic [CNT_W-1:0] Q3       = CNT_W'(Q3_CYCLE);
  localparam logic [CNT_W-1:0] STEP4    = CNT_W'(STEP4_CYCLE);
  localparam logic [CNT_W-1:0] STEP4_M1 = CNT_W'(STEP4_CYCLE - 1);
  localparam logic [CNT_W-1:0] STEP5    = CNT_W'(STEP5_CYCLE);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] wrap_val;
  logic [2:0]       pending;
  logic [2:0]       pending_nxt;
  logic             inhibit;
  logic             at_wrap;
  logic             pend_fire;
  logic             imm_event;
  logic             q_event;
  logic             h_event;
  logic             irq_set;
  logic             irq_clr;
  logic             irq_nxt;
  logic             data_unused;

  assign data_unused = ^data_in[5:0];

  // NOTE: every signal gets an unconditional value on every pass, so no latch can be inferred.
  always_comb begin
    wrap_val  = mode ? STEP5 : STEP4;
    at_wrap   = (cnt == wrap_val);
    // A write on the same edge reloads the delay, so only the newest write resets cnt.
    pend_fire = !write_4017 && (pending == 3'd1);
    imm_event = pend_fire && mode;

    // The immediate mode-1 event ORs with any decoded event: one toggle, not two.
    q_event   = (cnt == Q1) || (cnt == H1) || (cnt == Q3) || at_wrap || imm_event;
    h_event   = (cnt == H1) || at_wrap || imm_event;

    cnt_nxt   = (at_wrap || pend_fire) ? '0 : cnt + 1'b1;

    if (write_4017)
      pending_nxt = apu_phase ? 3'd4 : 3'd3;
    else if (pending != 3'd0)
      pending_nxt = pending - 3'd1;
    else
      pending_nxt = 3'd0;

    irq_set = !mode && !inhibit && ((cnt == STEP4_M1) || (cnt == STEP4));
    irq_clr = status_read || (write_4017 && data_in[6]);
    if (irq_set)
      irq_nxt = 1'b1;
    else if (irq_clr)
      irq_nxt = 1'b0;
    else
      irq_nxt = frame_irq;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      pending       <= 3'd0;
      apu_phase     <= 1'b0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      frame_irq     <= 1'b0;
      quarter_clk   <= 1'b0;
      half_clk      <= 1'b0;
      quarter_pulse <= 1'b0;
      half_pulse    <= 1'b0;
    end else begin
      apu_phase     <= ~apu_phase;
      cnt           <= cnt_nxt;
      pending       <= pending_nxt;
      frame_irq     <= irq_nxt;
      quarter_pulse <= q_event;
      half_pulse    <= h_event;
      if (q_event) quarter_clk <= ~quarter_clk;
      if (h_event) half_clk    <= ~half_clk;
      if (write_4017) begin
        mode    <= data_in[7];
        inhibit <= data_in[6];
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer: frame timing in both modes, IRQ
// set/clear priority, $4017 write delays and asynchronous reset.

module tb_apu_frame_sequencer;

  logic       cpu_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_4017 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       status_read = 1'b0;
  logic       quarter_clk, half_clk, quarter_pulse, half_pulse;
  logic       frame_irq, mode, apu_phase;

  int checks = 0;
  int errors = 0;

  int q_hits[$];
  int h_hits[$];
  int irq_rises[$];
  int q_toggles, h_toggles, irq_high;

  apu_frame_sequencer dut (
    .cpu_clk      (cpu_clk),
    .reset_n      (reset_n),
    .write_4017   (write_4017),
    .data_in      (data_in),
    .status_read  (status_read),
    .quarter_clk  (quarter_clk),
    .half_clk     (half_clk),
    .quarter_pulse(quarter_pulse),
    .half_pulse   (half_pulse),
    .frame_irq    (frame_irq),
    .mode         (mode),
    .apu_phase    (apu_phase)
  );

  initial forever #5 cpu_clk = ~cpu_clk;

  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input int a[$]);
    string s;
    s = $sformatf("n=%0d:", a.size());
    for (int i = 0; i < a.size() && i < 6; i++) s = {s, $sformatf(" %0d", a[i])};
    return s;
  endfunction

  // Runs n cycles; positions are counted in edges from the call, sampled on negedges.
  task automatic run_log(input int n);
    logic pq, ph, pi;
    q_hits.delete(); h_hits.delete(); irq_rises.delete();
    q_toggles = 0; h_toggles = 0; irq_high = 0;
    pq = quarter_clk; ph = half_clk; pi = frame_irq;
    for (int i = 1; i <= n; i++) begin
      @(negedge cpu_clk);
      if (quarter_pulse) q_hits.push_back(i);
      if (half_pulse) h_hits.push_back(i);
      if (quarter_clk !== pq) q_toggles++;
      if (half_clk !== ph) h_toggles++;
      if (frame_irq && !pi) irq_rises.push_back(i);
      if (frame_irq) irq_high++;
      pq = quarter_clk; ph = half_clk; pi = frame_irq;
    end
  endtask

  // Waits (bounded) for the requested apu_phase, then issues a one-cycle $4017 write.
  task automatic do_write(input logic [7:0] d, input logic want_phase);
    int tries = 0;
    while (apu_phase !== want_phase && tries < 4) begin
      @(negedge cpu_clk);
      tries++;
    end
    checks++;
    if (apu_phase !== want_phase) begin
      errors++;
      $display("FAIL write_phase_wait: apu_phase=%b required=%b", apu_phase, want_phase);
    end
    write_4017 = 1'b1;
    data_in    = d;
    @(negedge cpu_clk);
    write_4017 = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge cpu_clk);
    checks++;
    if ({quarter_clk, half_clk, quarter_pulse, half_pulse, frame_irq, mode, apu_phase} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {quarter_clk, half_clk, quarter_pulse, half_pulse, frame_irq, mode, apu_phase});
    end
  endtask

  task automatic test_async_reset();
    reset_n = 1'b1;
    repeat (20) @(negedge cpu_clk);
    do_write(8'hC0, 1'b0);
    repeat (3) @(negedge cpu_clk);
    checks++;
    if ({quarter_pulse, half_pulse, quarter_clk, half_clk, mode} !== 5'b11111) begin
      errors++;
      $display("FAIL pre_reset_state: got %b required 11111",
               {quarter_pulse, half_pulse, quarter_clk, half_clk, mode});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({quarter_clk, half_clk, quarter_pulse, half_pulse, frame_irq, mode, apu_phase} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0000000",
               {quarter_clk, half_clk, quarter_pulse, half_pulse, frame_irq, mode, apu_phase});
    end
    @(negedge cpu_clk);
    reset_n = 1'b1;
  endtask

  // Mode-0 frame from reset release; status_read collides with the cnt==29829 set.
  task automatic test_mode0_frame();
    int exp_q[$];
    int exp_h[$];
    int exp_i[$];
    run_log(29829);
    exp_q = '{7458, 14914, 22372};
    exp_h = '{14914};
    exp_i = '{29829};
    checks++;
    if (!same(q_hits, exp_q)) begin
      errors++;
      $display("FAIL m0_quarter: got %s required %s", fmt(q_hits), fmt(exp_q));
    end
    checks++;
    if (!same(h_hits, exp_h)) begin
      errors++;
      $display("FAIL m0_half: got %s required %s", fmt(h_hits), fmt(exp_h));
    end
    checks++;
    if (!same(irq_rises, exp_i)) begin
      errors++;
      $display("FAIL m0_irq_rise: got %s required %s", fmt(irq_rises), fmt(exp_i));
    end
    checks++;
    if (q_toggles != 3 || h_toggles != 1) begin
      errors++;
      $display("FAIL m0_toggle_count: got q=%0d h=%0d required q=3 h=1", q_toggles, h_toggles);
    end
    status_read = 1'b1;
    @(negedge cpu_clk);
    status_read = 1'b0;
    checks++;
    if (frame_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: frame_irq=%b required 1", frame_irq);
    end
    checks++;
    if ({quarter_pulse, half_pulse} !== 2'b11 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL m0_wrap: pulses=%b cnt=%0d required 11 and 0", {quarter_pulse, half_pulse}, dut.cnt);
    end
    checks++;
    if ({quarter_clk, half_clk} !== 2'b00) begin
      errors++;
      $display("FAIL toggle_parity: got %b required 00", {quarter_clk, half_clk});
    end
  endtask

  task automatic test_status_clear();
    status_read = 1'b1;
    @(negedge cpu_clk);
    status_read = 1'b0;
    checks++;
    if (frame_irq !== 1'b0) begin
      errors++;
      $display("FAIL status_clear: frame_irq=%b required 0", frame_irq);
    end
  endtask

  task automatic test_inhibit();
    int exp_q[$];
    do_write(8'h40, 1'b0);
    repeat (3) @(negedge cpu_clk);
    checks++;
    if (dut.cnt !== 16'd0 || mode !== 1'b0) begin
      errors++;
      $display("FAIL inhibit_write_reset: cnt=%0d mode=%b required 0 and 0", dut.cnt, mode);
    end
    run_log(29830);
    exp_q = '{7458, 14914, 22372, 29830};
    checks++;
    if (irq_high != 0) begin
      errors++;
      $display("FAIL inhibit_irq: frame_irq high for %0d cycles required 0", irq_high);
    end
    checks++;
    if (!same(q_hits, exp_q)) begin
      errors++;
      $display("FAIL inhibit_quarter: got %s required %s", fmt(q_hits), fmt(exp_q));
    end
  endtask

  task automatic test_mode1();
    int exp_q[$];
    int exp_h[$];
    do_write(8'h80, 1'b0);
    repeat (2) @(negedge cpu_clk);
    checks++;
    if (quarter_pulse !== 1'b0 || dut.cnt === 16'd0) begin
      errors++;
      $display("FAIL m1_early: quarter_pulse=%b cnt=%0d required 0 and nonzero", quarter_pulse, dut.cnt);
    end
    @(negedge cpu_clk);
    checks++;
    if ({quarter_pulse, half_pulse, mode} !== 3'b111 || dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL m1_immediate: pulses/mode=%b cnt=%0d required 111 and 0",
               {quarter_pulse, half_pulse, mode}, dut.cnt);
    end
    run_log(37282);
    exp_q = '{7458, 14914, 22372, 37282};
    exp_h = '{14914, 37282};
    checks++;
    if (!same(q_hits, exp_q)) begin
      errors++;
      $display("FAIL m1_quarter: got %s required %s", fmt(q_hits), fmt(exp_q));
    end
    checks++;
    if (!same(h_hits, exp_h)) begin
      errors++;
      $display("FAIL m1_half: got %s required %s", fmt(h_hits), fmt(exp_h));
    end
    checks++;
    if (irq_high != 0) begin
      errors++;
      $display("FAIL m1_irq: frame_irq high for %0d cycles required 0", irq_high);
    end
  endtask

  task automatic test_write_phase1();
    logic any_pulse = 1'b0;
    do_write(8'h00, 1'b1);
    repeat (3) begin
      @(negedge cpu_clk);
      any_pulse |= quarter_pulse | half_pulse;
    end
    checks++;
    if (dut.cnt === 16'd0) begin
      errors++;
      $display("FAIL phase1_early: cnt=%0d required nonzero", dut.cnt);
    end
    @(negedge cpu_clk);
    any_pulse |= quarter_pulse | half_pulse;
    checks++;
    if (dut.cnt !== 16'd0 || mode !== 1'b0) begin
      errors++;
      $display("FAIL phase1_reset: cnt=%0d mode=%b required 0 and 0", dut.cnt, mode);
    end
    checks++;
    if (any_pulse !== 1'b0) begin
      errors++;
      $display("FAIL phase1_no_event: pulse seen=%b required 0", any_pulse);
    end
  endtask

  task automatic test_back_to_back();
    do_write(8'h00, 1'b0);
    do_write(8'h00, 1'b0);
    repeat (2) begin
      @(negedge cpu_clk);
      checks++;
      if (dut.cnt === 16'd0) begin
        errors++;
        $display("FAIL b2b_early_reset: cnt=%0d required nonzero", dut.cnt);
      end
    end
    @(negedge cpu_clk);
    checks++;
    if (dut.cnt !== 16'd0) begin
      errors++;
      $display("FAIL b2b_reset: cnt=%0d required 0", dut.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_mode0_frame();
    test_status_clear();
    test_inhibit();
    test_mode1();
    test_write_phase1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
